// File: rtl/pc_pkg.sv
// Shared definitions for the PC update logic: widths, shift amount and FSM encodings.
package pc_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned INSTR_SHIFT = 2;   // instruction index to byte offset

    typedef enum logic [1:0] {
        StBoot     = 2'd0,
        StRun      = 2'd1,
        StStall    = 2'd2,
        StRedirect = 2'd3
    } pc_state_e;

endpackage

// File: rtl/offset_extender.sv
// Turns a signed 8-bit instruction distance into a signed 32-bit byte offset.
module offset_extender
    import pc_pkg::*;
(
    input  logic [7:0]      addval,
    output logic [PC_W-1:0] offset
);

    // Sign-extend, then scale from instructions to bytes.
    assign offset = {{(PC_W - 8 - INSTR_SHIFT){addval[7]}}, addval, {INSTR_SHIFT{1'b0}}};

endmodule

// File: rtl/pc_update_unit.sv
// Program counter sequencer: boot hold, sequential advance, branch redirect with a
// one-cycle flush marker, memory stall handling and a retired-advance counter.
module pc_update_unit
    import pc_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'd0,
    parameter int unsigned     CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             BUSYWAIT,
    input  logic [7:0]       ADDVAL,
    output logic [PC_W-1:0]  PC,
    output logic [PC_W-1:0]  PC_PLUS4,
    output logic             FLUSH,
    output logic [CNT_W-1:0] RETIRED,
    output logic [1:0]       STATE
);

    pc_state_e        state_q;
    logic [PC_W-1:0]  pc_q;
    logic [CNT_W-1:0] retired_q;
    logic             flush_q;

    logic [PC_W-1:0]  pc_plus4;
    logic [PC_W-1:0]  offset;
    logic [PC_W-1:0]  target;

    offset_extender u_offset_extender (
        .addval (ADDVAL),
        .offset (offset)
    );

    assign pc_plus4 = pc_q + PC_W'(4);
    assign target   = pc_plus4 + offset;

    // FSM with registered PC, counter and flush marker; reset overrides everything.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StBoot;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            flush_q   <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state_q)
                StBoot: begin
                    state_q <= StRun;
                end
                StRun: begin
                    if (BUSYWAIT) begin
                        state_q <= StStall;
                    end else if (ADDVAL != 8'd0) begin
                        pc_q      <= target;
                        retired_q <= retired_q + CNT_W'(1);
                        flush_q   <= 1'b1;
                        state_q   <= StRedirect;
                    end else begin
                        pc_q      <= pc_plus4;
                        retired_q <= retired_q + CNT_W'(1);
                    end
                end
                StRedirect: begin
                    // ADDVAL is ignored here: the instruction in flight is being flushed.
                    if (BUSYWAIT) begin
                        state_q <= StStall;
                    end else begin
                        pc_q      <= pc_plus4;
                        retired_q <= retired_q + CNT_W'(1);
                        state_q   <= StRun;
                    end
                end
                StStall: begin
                    if (!BUSYWAIT) begin
                        state_q <= StRun;
                    end
                end
                default: begin
                    state_q <= StBoot;
                end
            endcase
        end
    end

    // Outputs straight from state, plus the combinational increment.
    always_comb begin
        PC       = pc_q;
        PC_PLUS4 = pc_plus4;
        FLUSH    = flush_q;
        RETIRED  = retired_q;
        STATE    = state_q;
    end

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed-vector bench for pc_update_unit.
module tb_pc_update_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        BUSYWAIT;
    logic [7:0]  ADDVAL;
    logic [31:0] PC;
    logic [31:0] PC_PLUS4;
    logic        FLUSH;
    logic [15:0] RETIRED;
    logic [1:0]  STATE;

    int total = 0;
    int bad   = 0;

    pc_update_unit #(
        .RESET_PC (32'd0),
        .CNT_W    (16)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .BUSYWAIT (BUSYWAIT),
        .ADDVAL   (ADDVAL),
        .PC       (PC),
        .PC_PLUS4 (PC_PLUS4),
        .FLUSH    (FLUSH),
        .RETIRED  (RETIRED),
        .STATE    (STATE)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reset, leave BOOT, then n sequential advances: PC = 4n, RETIRED = n, STATE = RUN.
    task automatic reset_and_run(input int n);
        RESET = 1'b1; BUSYWAIT = 1'b0; ADDVAL = 8'd0;
        tick();
        RESET = 1'b0;
        tick();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1; BUSYWAIT = 1'b1; ADDVAL = 8'h33;
        tick();
        total++; if (PC !== 32'd0) begin $display("FAIL reset_pc got=%0h exp=0", PC); bad++; end
        total++; if (RETIRED !== 16'd0) begin $display("FAIL reset_retired got=%0d exp=0", RETIRED); bad++; end
        total++; if (FLUSH !== 1'b0) begin $display("FAIL reset_flush got=%0b exp=0", FLUSH); bad++; end
        total++; if (STATE !== 2'd0) begin $display("FAIL reset_state got=%0d exp=0", STATE); bad++; end
        total++; if (PC_PLUS4 !== 32'd4) begin $display("FAIL reset_pc_plus4 got=%0h exp=4", PC_PLUS4); bad++; end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [4] = '{32'd0, 32'd4, 32'd8, 32'd12};
        logic [1:0]  exp_st [4] = '{2'd1, 2'd1, 2'd1, 2'd1};
        RESET = 1'b0; BUSYWAIT = 1'b0; ADDVAL = 8'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (PC !== exp_pc[i]) begin $display("FAIL seq_pc[%0d] got=%0h exp=%0h", i, PC, exp_pc[i]); bad++; end
            total++; if (STATE !== exp_st[i]) begin $display("FAIL seq_state[%0d] got=%0d exp=%0d", i, STATE, exp_st[i]); bad++; end
            total++; if (PC_PLUS4 !== exp_pc[i] + 32'd4) begin $display("FAIL seq_pc_plus4[%0d] got=%0h exp=%0h", i, PC_PLUS4, exp_pc[i] + 32'd4); bad++; end
        end
        total++; if (RETIRED !== 16'd3) begin $display("FAIL seq_retired got=%0d exp=3", RETIRED); bad++; end
    endtask

    task automatic test_branch_forward();
        reset_and_run(2);
        ADDVAL = 8'h03;
        tick();
        total++; if (PC !== 32'd24) begin $display("FAIL fwd_pc got=%0d exp=24", PC); bad++; end
        total++; if (FLUSH !== 1'b1) begin $display("FAIL fwd_flush got=%0b exp=1", FLUSH); bad++; end
        total++; if (STATE !== 2'd3) begin $display("FAIL fwd_state got=%0d exp=3", STATE); bad++; end
        total++; if (RETIRED !== 16'd3) begin $display("FAIL fwd_retired got=%0d exp=3", RETIRED); bad++; end
        ADDVAL = 8'd0;
        tick();
        total++; if (PC !== 32'd28) begin $display("FAIL fwd_next_pc got=%0d exp=28", PC); bad++; end
        total++; if (FLUSH !== 1'b0) begin $display("FAIL fwd_flush_drop got=%0b exp=0", FLUSH); bad++; end
        total++; if (STATE !== 2'd1) begin $display("FAIL fwd_next_state got=%0d exp=1", STATE); bad++; end
        total++; if (RETIRED !== 16'd4) begin $display("FAIL fwd_next_retired got=%0d exp=4", RETIRED); bad++; end
    endtask

    task automatic test_branch_backward();
        reset_and_run(10);
        ADDVAL = 8'hFE;
        tick();
        total++; if (PC !== 32'd36) begin $display("FAIL back_pc got=%0d exp=36", PC); bad++; end
        total++; if (RETIRED !== 16'd11) begin $display("FAIL back_retired got=%0d exp=11", RETIRED); bad++; end
        reset_and_run(9);
        ADDVAL = 8'hFF;
        tick();
        total++; if (PC !== 32'd36) begin $display("FAIL self_pc got=%0d exp=36", PC); bad++; end
        total++; if (RETIRED !== 16'd10) begin $display("FAIL self_retired got=%0d exp=10", RETIRED); bad++; end
        total++; if (FLUSH !== 1'b1) begin $display("FAIL self_flush got=%0b exp=1", FLUSH); bad++; end
        // Still 8'hFF, but REDIRECT ignores ADDVAL and steps sequentially.
        tick();
        total++; if (PC !== 32'd40) begin $display("FAIL redir_ignore_pc got=%0d exp=40", PC); bad++; end
        total++; if (RETIRED !== 16'd11) begin $display("FAIL redir_ignore_retired got=%0d exp=11", RETIRED); bad++; end
        total++; if (STATE !== 2'd1) begin $display("FAIL redir_ignore_state got=%0d exp=1", STATE); bad++; end
        ADDVAL = 8'd0;
    endtask

    task automatic test_extremes();
        reset_and_run(0);
        ADDVAL = 8'h7F;
        tick();
        total++; if (PC !== 32'd512) begin $display("FAIL max_fwd_pc got=%0d exp=512", PC); bad++; end
        ADDVAL = 8'd0;
        tick();
        total++; if (PC !== 32'd516) begin $display("FAIL max_fwd_next got=%0d exp=516", PC); bad++; end
        ADDVAL = 8'h80;
        tick();
        total++; if (PC !== 32'd8) begin $display("FAIL max_back_pc got=%0d exp=8", PC); bad++; end
        ADDVAL = 8'd0;
    endtask

    task automatic test_stall();
        reset_and_run(3);
        BUSYWAIT = 1'b1; ADDVAL = 8'h05;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (PC !== 32'd12) begin $display("FAIL stall_pc[%0d] got=%0d exp=12", i, PC); bad++; end
            total++; if (STATE !== 2'd2) begin $display("FAIL stall_state[%0d] got=%0d exp=2", i, STATE); bad++; end
            total++; if (FLUSH !== 1'b0) begin $display("FAIL stall_flush[%0d] got=%0b exp=0", i, FLUSH); bad++; end
            total++; if (RETIRED !== 16'd3) begin $display("FAIL stall_retired[%0d] got=%0d exp=3", i, RETIRED); bad++; end
        end
        BUSYWAIT = 1'b0; ADDVAL = 8'd0;
        tick();
        total++; if (STATE !== 2'd1) begin $display("FAIL unstall_state got=%0d exp=1", STATE); bad++; end
        total++; if (PC !== 32'd12) begin $display("FAIL unstall_pc got=%0d exp=12", PC); bad++; end
        tick();
        total++; if (PC !== 32'd16) begin $display("FAIL unstall_next_pc got=%0d exp=16", PC); bad++; end
        total++; if (RETIRED !== 16'd4) begin $display("FAIL unstall_retired got=%0d exp=4", RETIRED); bad++; end
    endtask

    task automatic test_redirect_stall();
        reset_and_run(2);
        ADDVAL = 8'h01;
        tick();
        total++; if (PC !== 32'd16) begin $display("FAIL rs_pc got=%0d exp=16", PC); bad++; end
        BUSYWAIT = 1'b1; ADDVAL = 8'd0;
        tick();
        total++; if (STATE !== 2'd2) begin $display("FAIL rs_state got=%0d exp=2", STATE); bad++; end
        total++; if (PC !== 32'd16) begin $display("FAIL rs_hold_pc got=%0d exp=16", PC); bad++; end
        total++; if (FLUSH !== 1'b0) begin $display("FAIL rs_flush got=%0b exp=0", FLUSH); bad++; end
        total++; if (RETIRED !== 16'd3) begin $display("FAIL rs_retired got=%0d exp=3", RETIRED); bad++; end
        BUSYWAIT = 1'b0;
        tick();
        tick();
        total++; if (PC !== 32'd20) begin $display("FAIL rs_resume_pc got=%0d exp=20", PC); bad++; end
    endtask

    task automatic test_reset_midflight();
        reset_and_run(25);
        BUSYWAIT = 1'b1;
        tick();
        total++; if (PC !== 32'd100) begin $display("FAIL mid_stall_pc got=%0d exp=100", PC); bad++; end
        RESET = 1'b1;
        tick();
        total++; if (PC !== 32'd0) begin $display("FAIL mid_stall_rst_pc got=%0d exp=0", PC); bad++; end
        total++; if (RETIRED !== 16'd0) begin $display("FAIL mid_stall_rst_retired got=%0d exp=0", RETIRED); bad++; end
        total++; if (STATE !== 2'd0) begin $display("FAIL mid_stall_rst_state got=%0d exp=0", STATE); bad++; end
        total++; if (FLUSH !== 1'b0) begin $display("FAIL mid_stall_rst_flush got=%0b exp=0", FLUSH); bad++; end
        reset_and_run(1);
        ADDVAL = 8'h02;
        tick();
        RESET = 1'b1;
        tick();
        total++; if (STATE !== 2'd0) begin $display("FAIL mid_redir_rst_state got=%0d exp=0", STATE); bad++; end
        total++; if (FLUSH !== 1'b0) begin $display("FAIL mid_redir_rst_flush got=%0b exp=0", FLUSH); bad++; end
        RESET = 1'b0; ADDVAL = 8'd0; BUSYWAIT = 1'b0;
        tick();
        total++; if (PC !== 32'd0) begin $display("FAIL boot_hold_pc got=%0d exp=0", PC); bad++; end
        total++; if (STATE !== 2'd1) begin $display("FAIL boot_exit_state got=%0d exp=1", STATE); bad++; end
    endtask

    task automatic test_wrap();
        reset_and_run(0);
        ADDVAL = 8'hFD;
        tick();
        total++; if (PC !== 32'hFFFF_FFF8) begin $display("FAIL wrap_pc0 got=%0h exp=fffffff8", PC); bad++; end
        ADDVAL = 8'd0;
        tick();
        total++; if (PC !== 32'hFFFF_FFFC) begin $display("FAIL wrap_pc1 got=%0h exp=fffffffc", PC); bad++; end
        total++; if (PC_PLUS4 !== 32'd0) begin $display("FAIL wrap_plus4_1 got=%0h exp=0", PC_PLUS4); bad++; end
        tick();
        total++; if (PC !== 32'd0) begin $display("FAIL wrap_pc2 got=%0h exp=0", PC); bad++; end
        total++; if (PC_PLUS4 !== 32'd4) begin $display("FAIL wrap_plus4_2 got=%0h exp=4", PC_PLUS4); bad++; end
    endtask

    initial begin
        RESET = 1'b1; BUSYWAIT = 1'b0; ADDVAL = 8'd0;
        test_reset();
        test_sequential();
        test_branch_forward();
        test_branch_backward();
        test_extremes();
        test_stall();
        test_redirect_stall();
        test_reset_midflight();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_update_unit.md
PC_UPDATE_UNIT -- requirements
Module: pc_update_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'd0, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the retired-instruction counter.
REQ-003 SHALL have port CLK  input  1  system clock; all state updates occur on the rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port BUSYWAIT  input  1  instruction/data memory stall request; high means hold.
REQ-006 SHALL have port ADDVAL  input  8  signed branch/jump distance in instructions, already zero-gated by the branch decision (0 = no redirect).
REQ-007 SHALL have port PC  output  32  current instruction address.
REQ-008 SHALL have port PC_PLUS4  output  32  PC + 4, combinational.
REQ-009 SHALL have port FLUSH  output  1  one-cycle pulse marking the fetched instruction after a taken redirect as invalid.
REQ-010 SHALL have port RETIRED  output  CNT_W  count of PC advances since reset.
REQ-011 SHALL have port STATE  output  2  current FSM state, for debug.

Function
REQ-012 SHALL implement FSM states BOOT (2'd0), RUN (2'd1), STALL (2'd2), REDIRECT (2'd3).
REQ-013 SHALL compute the target as PC + 4 + (sign_extend(ADDVAL) << 2), modulo 2^32.
REQ-014 SHALL stay in BOOT for exactly one cycle after reset release, holding PC, then enter RUN.
REQ-015 In RUN with BUSYWAIT=0 and ADDVAL=0, SHALL load PC <= PC + 4 and remain in RUN.
REQ-016 In RUN with BUSYWAIT=0 and ADDVAL!=0, SHALL load PC <= target and enter REDIRECT.
REQ-017 In REDIRECT, SHALL assert FLUSH=1 for that cycle only, ignore ADDVAL, and advance PC <= PC + 4 if BUSYWAIT=0.
REQ-018 REDIRECT SHALL go to RUN if BUSYWAIT=0, otherwise to STALL with FLUSH still pulsed once.
REQ-019 In RUN or REDIRECT with BUSYWAIT=1, SHALL hold PC and enter STALL.
REQ-020 In STALL, SHALL hold PC and RETIRED and ignore ADDVAL; on BUSYWAIT=0, SHALL return to RUN without updating PC that cycle.
REQ-021 In RUN, ADDVAL SHALL be sampled only in cycles where BUSYWAIT=0; a nonzero ADDVAL present during a stall is not latched.
REQ-022 SHALL increment RETIRED by 1 on every PC update (PC+4 or target), wrapping from all-ones to 0.
REQ-023 ADDVAL=8'hFF SHALL give target = PC (self-loop); ADDVAL=8'h80 gives PC + 4 - 512; ADDVAL=8'h7F gives PC + 4 + 508.
REQ-024 PC arithmetic SHALL wrap modulo 2^32 without error indication (32'hFFFFFFFC + 4 = 0).
REQ-025 PC_PLUS4 SHALL always equal PC + 4 (mod 2^32) in the same cycle.
REQ-026 FLUSH SHALL be 0 in every state except REDIRECT.

Reset
REQ-027 RESET=1 at a rising edge SHALL set PC=RESET_PC, RETIRED=0, FLUSH=0, STATE=BOOT, overriding all other inputs, including mid-STALL and mid-REDIRECT.
REQ-028 Outputs SHALL be defined only from registered state plus PC_PLUS4 logic; no output SHALL depend on RESET combinationally.

Structure
REQ-029 State encodings, PC width (32) and the instruction-to-byte shift (2) SHALL reside in a shared package, pc_pkg.
REQ-030 The offset sign-extend-and-shift SHALL be one sub-module, offset_extender (8-bit in, 32-bit out).
REQ-031 SHALL contain no latches; all PC, RETIRED, STATE and FLUSH storage SHALL be rising-edge flops on CLK.

Verification
REQ-032 Reset, then 4 cycles with BUSYWAIT=0, ADDVAL=0 -> PC 0,0(BOOT),4,8,12; RETIRED=3.
REQ-033 At PC=8, ADDVAL=8'h03 for one cycle -> PC=24, FLUSH=1 for exactly one cycle, next PC=28.
REQ-034 At PC=40, ADDVAL=8'hFE -> PC=36; ADDVAL=8'hFF at PC=36 -> PC stays 36, RETIRED still increments.
REQ-035 BUSYWAIT=1 for 3 cycles at PC=12 with ADDVAL=8'h05 present -> PC holds at 12, no redirect, STATE=STALL; release -> RUN, then PC=16.
REQ-036 RESET asserted during STALL at PC=100 -> next edge PC=RESET_PC, RETIRED=0, STATE=BOOT, FLUSH=0.
REQ-037 PC=32'hFFFFFFF8, ADDVAL=0 for 2 cycles -> PC 32'hFFFFFFFC then 32'h0, PC_PLUS4 tracking.
